// File: rtl/logic_unit_pkg.sv
// Shared types for the logic unit: the op-code enum built on the shared defines.
`include "logic_ops.vh"

package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND      = `LOP_AND,
        OP_OR       = `LOP_OR,
        OP_XOR      = `LOP_XOR,
        OP_NOR      = `LOP_NOR,
        OP_ANDN     = `LOP_ANDN,
        OP_ACC_AND  = `LOP_ACC_AND,
        OP_ACC_OR   = `LOP_ACC_OR,
        OP_ACC_LOAD = `LOP_ACC_LOAD
    } lop_e;

    // Accumulate ops are the only ones that commit into the accumulator.
    function automatic logic is_acc_op(input lop_e op);
        return (op == OP_ACC_AND) || (op == OP_ACC_OR) || (op == OP_ACC_LOAD);
    endfunction

endpackage

// File: rtl/logic_ops.vh
// Op-code constants for the logic slice, shared with the ALU decoder.
`ifndef LOGIC_OPS_VH
`define LOGIC_OPS_VH

`define LOP_AND      3'd0
`define LOP_OR       3'd1
`define LOP_XOR      3'd2
`define LOP_NOR      3'd3
`define LOP_ANDN     3'd4
`define LOP_ACC_AND  3'd5
`define LOP_ACC_OR   3'd6
`define LOP_ACC_LOAD 3'd7

`endif

// File: rtl/logic_unit_core.sv
// Combinational operation decode: result and accumulator write-enable for one op.
module logic_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             acc_we
);

    lop_e op_e;

    always_comb begin
        op_e   = lop_e'(op);
        result = '0;
        case (op_e)
            OP_AND:      result = a & b;
            OP_OR:       result = a | b;
            OP_XOR:      result = a ^ b;
            OP_NOR:      result = ~(a | b);
            OP_ANDN:     result = a & ~b;
            OP_ACC_AND:  result = acc & a;
            OP_ACC_OR:   result = acc | a;
            OP_ACC_LOAD: result = a;
            default:     result = '0;
        endcase
        acc_we = is_acc_op(op_e);
    end

endmodule

// File: rtl/logic_unit.sv
// Registered bitwise logic unit with accumulator and valid/ready on both sides.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             ones,
    output logic [WIDTH-1:0] acc
);

    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] core_result;
    logic             core_acc_we;
    logic             accept;
    logic             deliver;

    logic_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a      (a),
        .b      (b),
        .acc    (acc_q),
        .op     (op),
        .result (core_result),
        .acc_we (core_acc_we)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid_q && out_ready;

    // Flags come from the value about to be registered so they line up with q.
    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        ones_d      = ones_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            result_d    = core_result;
            zero_d      = ~|core_result;
            ones_d      = &core_result;
            out_valid_d = 1'b1;
            if (core_acc_we) begin
                acc_d = core_result;
            end
        end else if (deliver) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            ones_q      <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign q         = result_q;
    assign zero      = zero_q;
    assign ones      = ones_q;
    assign acc       = acc_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_logic_unit.sv
// Directed bench for logic_unit at WIDTH=8 with hand-computed expected values.
`timescale 1ns/1ps
module tb_logic_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] q;
    logic         zero;
    logic         ones;
    logic [W-1:0] acc;

    int n_cmp = 0;
    int n_bad = 0;

    logic_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .zero      (zero),
        .ones      (ones),
        .acc       (acc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] exp_basic [5] = '{8'h30, 8'hFC, 8'hCC, 8'h03, 8'hC0};

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_q", q, 8'h00);
        check("rst_zero", zero, 1);
        check("rst_ones", ones, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_acc", acc, 8'h00);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_q", q, 8'h00);
        check("post_rst_zero", zero, 1);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_acc", acc, 8'h00);

        // Ops 0-4 back to back on a=F0, b=3C.
        a = 8'hF0; b = 8'h3C; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op = 3'(i);
            check($sformatf("basic_in_ready_%0d", i), in_ready, 1);
            tick();
            check($sformatf("basic_q_%0d", i), q, exp_basic[i]);
            check($sformatf("basic_vld_%0d", i), out_valid, 1);
            check($sformatf("basic_acc_%0d", i), acc, 8'h00);
        end
        in_valid = 1'b0;
        tick();
        check("basic_drain_vld", out_valid, 0);
        check("basic_drain_q_hold", q, 8'hC0);

        // Accumulator chain.
        in_valid = 1'b1;
        op = 3'd7; a = 8'hFF; tick();
        check("acc_load_q", q, 8'hFF); check("acc_load_acc", acc, 8'hFF);
        check("acc_load_ones", ones, 1);
        op = 3'd5; a = 8'h0F; tick();
        check("acc_and_q", q, 8'h0F); check("acc_and_acc", acc, 8'h0F);
        op = 3'd6; a = 8'h80; tick();
        check("acc_or_q", q, 8'h8F); check("acc_or_acc", acc, 8'h8F);
        in_valid = 1'b0; tick();
        check("acc_drain_vld", out_valid, 0);

        // Stall: AND AA&55 held while a pending XOR waits.
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd0; a = 8'hAA; b = 8'h55;
        tick();
        check("stall_vld", out_valid, 1);
        op = 3'd2; a = 8'h12; b = 8'h34;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_q_%0d", i), q, 8'h00);
            check($sformatf("stall_zero_%0d", i), zero, 1);
            check($sformatf("stall_in_ready_%0d", i), in_ready, 0);
            check($sformatf("stall_vld_%0d", i), out_valid, 1);
            check($sformatf("stall_acc_%0d", i), acc, 8'h8F);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", in_ready, 1);
        tick();
        check("unstall_q", q, 8'h26);
        check("unstall_vld", out_valid, 1);
        check("unstall_zero", zero, 0);
        in_valid = 1'b0; tick();
        check("unstall_drain_vld", out_valid, 0);

        // Reset during a stalled ACC_LOAD.
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd7; a = 8'h5A;
        tick();
        check("pre_rst_acc", acc, 8'h5A);
        check("pre_rst_vld", out_valid, 1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_vld", out_valid, 0);
        check("mid_rst_acc", acc, 8'h00);
        check("mid_rst_q", q, 8'h00);
        check("mid_rst_zero", zero, 1);
        check("mid_rst_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; op = 3'd6; a = 8'h01;
        tick();
        check("after_rst_q", q, 8'h01);
        check("after_rst_acc", acc, 8'h01);

        // NOR of zeros gives all ones.
        op = 3'd3; a = 8'h00; b = 8'h00;
        tick();
        check("nor_q", q, 8'hFF);
        check("nor_ones", ones, 1);
        check("nor_zero", zero, 0);
        check("nor_acc_hold", acc, 8'h01);
        in_valid = 1'b0; tick();
        check("final_vld", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
